// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and default vectors for the fetch PC sequencer
package pc_pkg;

    localparam logic [31:0] PC_RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VECTOR_DEFAULT   = 32'h8000_0180;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        EXC_BUBBLE
    } pc_state_e;

    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_SEQ,
        SRC_JUMP,
        SRC_BRANCH,
        SRC_RAS,
        SRC_EXC
    } pc_src_e;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack; a push when full overwrites the oldest entry
module ras_stack #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [CNT_W-1:0] cnt_q;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign top_o   = mem_q[ptr_q - PTR_W'(1)];

    // ptr_q is the next write slot; the pointer keeps rotating even when full
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (pop_i && !empty_o) begin
            ptr_q <= ptr_q - PTR_W'(1);
            cnt_q <= cnt_q - CNT_W'(1);
        end else if (push_i) begin
            ptr_q <= ptr_q + PTR_W'(1);
            if (!full_o) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i && !pop_i) begin
            mem_q[ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC register with priority next-PC selection, boot/exception bubble and RAS
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               INC          = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR_DEFAULT),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(PC_EXC_VECTOR_DEFAULT),
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             Exception,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             Jump,
    input  logic [WIDTH-1:0] JumpTarget,
    input  logic             Call,
    input  logic             Return,
    output logic [WIDTH-1:0] PCResult,
    output logic             PCValid,
    output logic             RasEmpty,
    output logic             RasFull
);

    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             valid_q;
    pc_src_e          src_sel;
    logic             ras_push, ras_pop, ras_clear;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty, ras_full;
    logic [WIDTH-1:0] pc_seq;

    assign pc_seq = pc_q + WIDTH'(INC);

    always_comb begin
        src_sel   = SRC_HOLD;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        ras_clear = 1'b0;
        state_d   = state_q;
        unique case (state_q)
            BOOT: state_d = RUN;
            EXC_BUBBLE: begin
                if (Exception) src_sel = SRC_EXC;
                else           state_d = RUN;
            end
            RUN: begin
                if (Exception) begin
                    src_sel = SRC_EXC;
                end else if (BranchTaken) begin
                    src_sel = SRC_BRANCH;
                end else if (Stall) begin
                    src_sel = SRC_HOLD;
                // Return beats Call, but a plain Jump still beats Return
                end else if (Return && (Call || !Jump)) begin
                    if (!ras_empty) begin
                        src_sel = SRC_RAS;
                        ras_pop = 1'b1;
                    end else begin
                        src_sel = SRC_SEQ;
                    end
                end else if (Call || Jump) begin
                    src_sel  = SRC_JUMP;
                    ras_push = Call;
                end else begin
                    src_sel = SRC_SEQ;
                end
            end
            default: state_d = BOOT;
        endcase
        if (src_sel == SRC_EXC) begin
            state_d   = EXC_BUBBLE;
            ras_clear = 1'b1;
        end
    end

    always_comb begin
        pc_d = pc_q;
        unique case (src_sel)
            SRC_SEQ:    pc_d = pc_seq;
            SRC_JUMP:   pc_d = JumpTarget;
            SRC_BRANCH: pc_d = BranchTarget;
            SRC_RAS:    pc_d = ras_top;
            SRC_EXC:    pc_d = EXC_VECTOR;
            default:    pc_d = pc_q;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= (state_d == RUN);
        end
    end

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (Clk),
        .rst_ni      (Reset),
        .push_i      (ras_push),
        .push_data_i (pc_seq),
        .pop_i       (ras_pop),
        .clear_i     (ras_clear),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .full_o      (ras_full)
    );

    assign PCResult = pc_q;
    assign PCValid  = valid_q;
    assign RasEmpty = ras_empty;
    assign RasFull  = ras_full;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

    localparam logic [31:0] EXC = 32'h8000_0180;
    localparam int          DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Stall = 0, Exception = 0, BranchTaken = 0, Jump = 0, Call = 0, Return = 0;
    logic [31:0] BranchTarget = '0, JumpTarget = '0;
    logic [31:0] PCResult;
    logic        PCValid, RasEmpty, RasFull;

    logic        rst8 = 1'b0;
    logic        zero8 = 1'b0;
    logic [7:0]  tgt8 = '0;
    logic [7:0]  pc8;
    logic        valid8, empty8, full8;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    pc_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Exception(Exception),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .Jump(Jump), .JumpTarget(JumpTarget), .Call(Call), .Return(Return),
        .PCResult(PCResult), .PCValid(PCValid), .RasEmpty(RasEmpty), .RasFull(RasFull)
    );

    pc_sequencer #(.WIDTH(8), .RESET_VECTOR(8'hF8)) dut8 (
        .Clk(Clk), .Reset(rst8), .Stall(zero8), .Exception(zero8),
        .BranchTaken(zero8), .BranchTarget(tgt8),
        .Jump(zero8), .JumpTarget(tgt8), .Call(zero8), .Return(zero8),
        .PCResult(pc8), .PCValid(valid8), .RasEmpty(empty8), .RasFull(full8)
    );

    typedef struct {
        logic        stall, exc, br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic        call, ret;
        logic [31:0] pc;
        logic        valid, empty, full;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic s, logic e, logic b, logic [31:0] bt, logic j, logic [31:0] jt,
                                logic c, logic r, logic [31:0] pc, logic v, logic em, logic fu);
        vec_t x;
        x = '{s, e, b, bt, j, jt, c, r, pc, v, em, fu};
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic e, input logic b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt, input logic c, input logic r);
        Stall = s; Exception = e; BranchTaken = b; BranchTarget = bt;
        Jump = j; JumpTarget = jt; Call = c; Return = r;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic v,
                           input logic em, input logic fu);
        chk({tag, ".pc"}, PCResult, pc);
        chk({tag, ".valid"}, {31'b0, PCValid}, {31'b0, v});
        chk({tag, ".empty"}, {31'b0, RasEmpty}, {31'b0, em});
        chk({tag, ".full"}, {31'b0, RasFull}, {31'b0, fu});
    endtask

    // Reference model: PC plus a phase flag, RAS kept as an ordered list (oldest first)
    logic [31:0] m_pc;
    logic        m_valid;
    int          m_phase;
    logic [31:0] m_ras[$];

    task automatic model_reset;
        m_pc = 32'h0; m_valid = 1'b0; m_phase = 0; m_ras.delete();
    endtask

    task automatic model_ret;
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else                  m_pc = m_pc + 32'd4;
    endtask

    task automatic model_step;
        if (m_phase == 0) begin
            m_phase = 1; m_valid = 1'b1;
        end else if (Exception) begin
            m_pc = EXC; m_phase = 2; m_valid = 1'b0; m_ras.delete();
        end else if (m_phase == 2) begin
            m_phase = 1; m_valid = 1'b1;
        end else if (BranchTaken) begin
            m_pc = BranchTarget;
        end else if (Stall) begin
            m_pc = m_pc;
        end else if (Call && Return) begin
            model_ret();
        end else if (Call) begin
            if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
            m_ras.push_back(m_pc + 32'd4);
            m_pc = JumpTarget;
        end else if (Jump) begin
            m_pc = JumpTarget;
        end else if (Return) begin
            model_ret();
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    initial begin
        // Directed program: inputs applied for one cycle, outputs expected after the edge
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'h0,   1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'h4,   1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'h8,   1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'hC,   1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'h10,  1,1,0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,0,0,0,0,0, 32'h10, 1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'h14,  1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'h18,  1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'h1C,  1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'h20,  1,1,0));
        tbl.push_back(mk(1,0,1,32'h100,0,0,0,0, 32'h100, 1,1,0));
        tbl.push_back(mk(0,0,0,0,1,32'h0,0,0, 32'h0, 1,1,0));
        tbl.push_back(mk(0,0,0,0,0,32'h40,1,0,  32'h40,  1,0,0));
        tbl.push_back(mk(0,0,0,0,0,32'h80,1,0,  32'h80,  1,0,0));
        tbl.push_back(mk(0,0,0,0,0,32'hC0,1,0,  32'hC0,  1,0,0));
        tbl.push_back(mk(0,0,0,0,0,32'h100,1,0, 32'h100, 1,0,1));
        tbl.push_back(mk(0,0,0,0,0,32'h140,1,0, 32'h140, 1,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,1, 32'h104, 1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,1, 32'hC4,  1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,1, 32'h84,  1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,1, 32'h44,  1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,1, 32'h48,  1,1,0));
        tbl.push_back(mk(0,0,0,0,0,32'h200,1,0, 32'h200, 1,0,0));
        tbl.push_back(mk(1,0,0,0,0,32'h500,1,0, 32'h200, 1,0,0));
        tbl.push_back(mk(0,0,0,0,0,32'h500,1,1, 32'h4C,  1,1,0));
        tbl.push_back(mk(0,0,0,0,0,32'h200,1,0, 32'h200, 1,0,0));
        tbl.push_back(mk(0,1,1,32'h300,0,0,0,1, EXC, 0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, EXC,          1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, EXC + 32'd4,  1,1,0));
        tbl.push_back(mk(0,0,0,0,1,32'h34,0,0, 32'h34, 1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'h38, 1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'h3C, 1,1,0));

        repeat (2) step();
        chk_all("reset_held", 32'h0, 0, 1, 0);
        Reset = 1'b1;
        #1;
        chk_all("boot", 32'h0, 0, 1, 0);
        foreach (tbl[i]) begin
            drive(tbl[i].stall, tbl[i].exc, tbl[i].br, tbl[i].bt,
                  tbl[i].jmp, tbl[i].jt, tbl[i].call, tbl[i].ret);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].valid, tbl[i].empty, tbl[i].full);
        end
        drive(0,0,0,0,0,0,0,0);

        // Asynchronous reset between edges, then the boot sequence again
        #2 Reset = 1'b0;
        #1;
        chk_all("async_reset", 32'h0, 0, 1, 0);
        step();
        chk_all("reset_hold_edge", 32'h0, 0, 1, 0);
        Reset = 1'b1;
        #1;
        chk_all("reboot_bubble", 32'h0, 0, 1, 0);
        step(); chk_all("reboot0", 32'h0, 1, 1, 0);
        step(); chk_all("reboot1", 32'h4, 1, 1, 0);

        // Narrow instance: PC wraps from 0xFC to 0x00
        rst8 = 1'b1;
        #1 chk("w8.boot_pc", {24'b0, pc8}, 32'hF8);
        step(); chk("w8.pc0", {24'b0, pc8}, 32'hF8); chk("w8.v0", {31'b0, valid8}, 32'h1);
        step(); chk("w8.pc1", {24'b0, pc8}, 32'hFC);
        step(); chk("w8.wrap", {24'b0, pc8}, 32'h00);
        chk("w8.empty", {30'b0, empty8, full8}, 32'h2);

        // Random stimulus against the reference model
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom % 6) == 0, ($urandom % 40) == 0, ($urandom % 8) == 0,
                  {$urandom, 2'b00}, ($urandom % 8) == 0, {$urandom, 2'b00},
                  ($urandom % 4) == 0, ($urandom % 4) == 0);
            step();
            model_step();
            chk_all($sformatf("rnd%0d", n), m_pc, m_valid, m_ras.size() == 0, m_ras.size() == DEPTH);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
